tcp_hdr_extract: RTL and testbench
==================================

# tcp_hdr_extract

Parametrised TCP header extractor for the output-port-lookup path. It passively snoops an AXI4-Stream packet bus and decodes the Ethernet/IPv4/TCP header of each packet: all eight TCP flags, sequence and acknowledge numbers, payload length, expected next sequence number and the TCP timestamp option. It writes one metadata record per packet into an internal FIFO, which the lookup FSM drains with `rd_en`. It also keeps saturating packet and drop counters.

## Interface
- `C_S_AXIS_DATA_WIDTH`, default 256: bus width in bits; legal values are 64, 128, 256, 512.
- `C_S_AXIS_TUSER_WIDTH`, default 128: sideband width; `tuser[23:16]` is the source port.
- `FIFO_DEPTH_BITS`, default 5: metadata FIFO holds 2^FIFO_DEPTH_BITS records.
- `clk  in  1`: clock.
- `reset  in  1`: synchronous, active-high.
- `tdata  in  C_S_AXIS_DATA_WIDTH`: stream data. Byte k of a beat is `tdata[8k+7:8k]`; multi-byte fields are big-endian across bytes.
- `tvalid`, `tready`, `tlast  in  1 each`: the beat is accepted when `tvalid & tready`.
- `tuser  in  C_S_AXIS_TUSER_WIDTH`: sampled on the first beat of each packet.
- `rd_en  in  1`: pops the head record. Ignored when the FIFO is empty.
- `meta_vld  out  1`: asserted when the FIFO is not empty.
- `is_tcp  out  1`: EtherType is 0x0800, IP version is 4, IHL is 5, protocol is 6, and the header window is complete.
- `tcp_flags  out  8`: {CWR,ECE,URG,ACK,PSH,RST,SYN,FIN}, taken from byte 47.
- `seq_num`, `ack_num  out  32 each`: from bytes 38–41 and 42–45.
- `next_seq  out  32`: seq + payload_len + SYN + FIN, modulo 2^32.
- `payload_len  out  16`: IP total length − 20 − 4·data_offset. Forced to 0 on underflow.
- `ts_present  out  1`; `ts_val`, `ts_ecr  out  32 each`.
- `src_port  out  8`.
- `pkt_count`, `drop_count  out  16 each`: saturating counters.

## Operation
- A byte counter `boff` advances by C_S_AXIS_DATA_WIDTH/8 on every accepted beat.
  - It is cleared after a `tlast` beat and on reset.
  - The first accepted beat after reset or after `tlast` is the start of a packet.
- Header window capture:
  - Window is bytes 0–65 (66 bytes).
  - On each accepted beat, the bytes of the beat that fall inside the window are written into a 66-byte register at positions `boff+k`.
  - Bytes beyond byte 65 are ignored.
- A `hdr_full` flag is set once `boff + beat bytes` ≥ 66. A packet ending before that point gives `is_tcp`=0, and every other field of its record is 0 except `src_port`.
- Data offset is the upper nibble of byte 46. A value below 5 forces `is_tcp`=0.
- Timestamp option is detected only when data_offset ≥ 8, in one of two layouts:
  - Kind 8 / length 10 at bytes 54–55: ts_val is bytes 56–59, ts_ecr is bytes 60–63.
  - Bytes 54–55 are NOP,NOP (0x01,0x01) and kind 8 / length 10 is at bytes 56–57: ts_val is bytes 58–61, ts_ecr is bytes 62–65.
  - Otherwise `ts_present`=0 and both values are 0.
- Decode is registered. On the `tlast` beat, the record is computed from the window register plus the current beat's bytes, so a single-beat packet works.
- Record write happens on the edge after the `tlast` beat.
  - If the FIFO is not full: write the record and increment `pkt_count`.
  - If the FIFO is full: drop the record and increment both `drop_count` and `pkt_count`. The bus is never back-pressured.
- A simultaneous write and `rd_en` when the FIFO is full is still counted as a drop. Full is evaluated before the read.
- Outputs are first-word-fall-through: the head record is presented while `meta_vld`=1.

## Timing
- Reset values:
  - `meta_vld`=0; FIFO empty.
  - Every record output is 0.
  - `pkt_count`=`drop_count`=0.
  - `boff`=0; window register cleared.
- Latency: the `tlast` beat is accepted at edge N. The FIFO write occurs at edge N+1, and `meta_vld` is 1 after edge N+1.
- Throughput: one record per clock. Back-to-back single-beat packets (512-bit bus) write on consecutive edges with no loss while the FIFO is not full.
- `rd_en` at edge M removes the head record. The next record (or `meta_vld`=0) is visible after edge M.
- Read and write in the same cycle keep the occupancy constant.
- Reset during a packet:
  - The partial packet is discarded with no record and no count.
  - The first accepted beat after reset starts a new packet.
- Counters hold at 0xFFFF.
- `next_seq` and `payload_len` arithmetic wrap at 32 and 16 bits. Wrap is intended.

## Test plan
- SYN-ACK at 256 bits, 66-byte packet in 3 beats: flags 0x12, seq 0x1000_0000, data_offset 8, timestamp at bytes 56–65 (NOP,NOP layout). Required: `is_tcp`=1, `tcp_flags`=0x12, `next_seq`=0x1000_0001, `payload_len`=0, `ts_present`=1, and `meta_vld` rises one edge after the `tlast` edge.
- PSH|ACK, seq 0xFFFF_FFF0, IP total length 152, data_offset 8. Required: `payload_len`=100 and `next_seq`=0x0000_0054 (wrap).
- UDP packet (protocol 17) and a 40-byte runt. Required: `is_tcp`=0 for both, `src_port` taken from `tuser`, `pkt_count`=2.
- 64-bit bus, FIN with no options, tvalid toggling every other cycle. Required: identical record to the same packet sent at 256 bits; `next_seq` = seq + 1.
- 40 back-to-back packets with `rd_en`=0 and FIFO_DEPTH_BITS=5. Required: 32 records stored, `drop_count`=8, `pkt_count`=40. Then drain: exactly 32 pops, in order.
- Reset asserted at the second beat of a packet, then one clean packet sent. Required: exactly one record and `pkt_count`=1.

Source files
------------

// File: rtl/tcp_hdr_extract.sv
// Passive TCP header extractor: snoops an AXI4-Stream bus, decodes the Ethernet/IPv4/TCP
// header of each packet and queues one metadata record per packet in a first-word-fall-through FIFO.
module tcp_hdr_extract #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int FIFO_DEPTH_BITS      = 5
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]  tdata,
  input  logic                            tvalid,
  input  logic                            tready,
  input  logic                            tlast,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0] tuser,
  input  logic                            rd_en,
  output logic                            meta_vld,
  output logic                            is_tcp,
  output logic [7:0]                      tcp_flags,
  output logic [31:0]                     seq_num,
  output logic [31:0]                     ack_num,
  output logic [31:0]                     next_seq,
  output logic [15:0]                     payload_len,
  output logic                            ts_present,
  output logic [31:0]                     ts_val,
  output logic [31:0]                     ts_ecr,
  output logic [7:0]                      src_port,
  output logic [15:0]                     pkt_count,
  output logic [15:0]                     drop_count
);
  localparam int BEAT_BYTES = C_S_AXIS_DATA_WIDTH / 8;
  localparam int WIN_BYTES  = 66;
  localparam int DEPTH_N    = 1 << FIFO_DEPTH_BITS;
  localparam logic [FIFO_DEPTH_BITS:0]   FULL_CNT = DEPTH_N[FIFO_DEPTH_BITS:0];
  localparam logic [FIFO_DEPTH_BITS:0]   CNT_ONE  = 1;
  localparam logic [FIFO_DEPTH_BITS-1:0] PTR_ONE  = 1;

  typedef struct packed {
    logic        is_tcp;
    logic [7:0]  tcp_flags;
    logic [31:0] seq_num;
    logic [31:0] ack_num;
    logic [31:0] next_seq;
    logic [15:0] payload_len;
    logic        ts_present;
    logic [31:0] ts_val;
    logic [31:0] ts_ecr;
    logic [7:0]  src_port;
  } rec_t;

  function automatic logic [7:0] beat_byte(input logic [C_S_AXIS_DATA_WIDTH-1:0] d, input int k);
    logic [C_S_AXIS_DATA_WIDTH-1:0] s;
    s = d >> (8 * k);
    return s[7:0];
  endfunction

  // Handshake: a beat moves only when tvalid & tready; this block observes and never drives tready.
  logic        accept;
  logic        sop;
  logic        hdr_full;
  logic [7:0]  boff_q;
  logic [7:0]  src_q;
  logic [7:0]  win_q [WIN_BYTES];
  logic [7:0]  win_c [WIN_BYTES];
  logic        unused_tuser;

  assign accept       = tvalid & tready;
  assign sop          = (boff_q == 8'd0);
  assign hdr_full     = (int'(boff_q) + BEAT_BYTES) >= WIN_BYTES;
  assign unused_tuser = ^tuser;

  // Window as seen this cycle: stored bytes overlaid with the bytes of the current beat.
  always_comb begin
    for (int i = 0; i < WIN_BYTES; i++) begin
      win_c[i] = win_q[i];
      if (i >= int'(boff_q) && i < int'(boff_q) + BEAT_BYTES)
        win_c[i] = beat_byte(tdata, i - int'(boff_q));
    end
  end

  logic [15:0] ether_type;
  logic [15:0] ip_len;
  logic [3:0]  doff;
  logic [16:0] pay_diff;
  logic [15:0] pay_len;
  logic        ts_a;
  logic        ts_b;
  rec_t        rec_c;
  rec_t        rec_q;
  logic        rec_vld_q;

  assign ether_type = {win_c[12], win_c[13]};
  assign ip_len     = {win_c[16], win_c[17]};
  assign doff       = win_c[46][7:4];
  assign pay_diff   = {1'b0, ip_len} - (17'd20 + {11'd0, doff, 2'b00});
  assign pay_len    = pay_diff[16] ? 16'd0 : pay_diff[15:0];
  assign ts_a = (doff >= 4'd8) && win_c[54] == 8'h08 && win_c[55] == 8'h0a;
  assign ts_b = (doff >= 4'd8) && win_c[54] == 8'h01 && win_c[55] == 8'h01 &&
                win_c[56] == 8'h08 && win_c[57] == 8'h0a;

  always_comb begin
    rec_c          = '0;
    rec_c.src_port = sop ? tuser[23:16] : src_q;
    if (hdr_full) begin
      rec_c.is_tcp      = ether_type == 16'h0800 && win_c[14] == 8'h45 &&
                          win_c[23] == 8'h06 && doff >= 4'd5;
      rec_c.tcp_flags   = win_c[47];
      rec_c.seq_num     = {win_c[38], win_c[39], win_c[40], win_c[41]};
      rec_c.ack_num     = {win_c[42], win_c[43], win_c[44], win_c[45]};
      rec_c.payload_len = pay_len;
      rec_c.next_seq    = rec_c.seq_num + {16'd0, pay_len} +
                          {31'd0, win_c[47][1]} + {31'd0, win_c[47][0]};
      if (ts_a) begin
        rec_c.ts_present = 1'b1;
        rec_c.ts_val     = {win_c[56], win_c[57], win_c[58], win_c[59]};
        rec_c.ts_ecr     = {win_c[60], win_c[61], win_c[62], win_c[63]};
      end else if (ts_b) begin
        rec_c.ts_present = 1'b1;
        rec_c.ts_val     = {win_c[58], win_c[59], win_c[60], win_c[61]};
        rec_c.ts_ecr     = {win_c[62], win_c[63], win_c[64], win_c[65]};
      end
    end
  end

  // boff stops advancing once past the window so long packets cannot wrap it back into range.
  always_ff @(posedge clk) begin
    if (reset) begin
      boff_q    <= '0;
      src_q     <= '0;
      rec_vld_q <= 1'b0;
      rec_q     <= '0;
      for (int i = 0; i < WIN_BYTES; i++) win_q[i] <= '0;
    end else begin
      rec_vld_q <= accept && tlast;
      if (accept) begin
        if (sop) src_q <= tuser[23:16];
        if (tlast) begin
          boff_q <= '0;
          rec_q  <= rec_c;
          for (int i = 0; i < WIN_BYTES; i++) win_q[i] <= '0;
        end else begin
          if (int'(boff_q) < WIN_BYTES) boff_q <= boff_q + 8'(BEAT_BYTES);
          for (int i = 0; i < WIN_BYTES; i++) win_q[i] <= win_c[i];
        end
      end
    end
  end

  rec_t                       mem [DEPTH_N];
  rec_t                       head;
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr;
  logic [FIFO_DEPTH_BITS-1:0] rd_ptr;
  logic [FIFO_DEPTH_BITS:0]   count;
  logic                       full;
  logic                       do_wr;
  logic                       do_rd;

  assign full     = (count == FULL_CNT);
  assign meta_vld = (count != '0);
  assign do_wr    = rec_vld_q && !full;
  assign do_rd    = rd_en && meta_vld;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= rec_q;
  end

  // Full is judged before any same-cycle pop, so a write into a full FIFO is a drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      pkt_count  <= '0;
      drop_count <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
      if (do_wr && !do_rd) count <= count + CNT_ONE;
      else if (!do_wr && do_rd) count <= count - CNT_ONE;
      if (rec_vld_q) begin
        if (pkt_count != 16'hffff) pkt_count <= pkt_count + 16'd1;
        if (full && drop_count != 16'hffff) drop_count <= drop_count + 16'd1;
      end
    end
  end

  assign head        = meta_vld ? mem[rd_ptr] : '0;
  assign is_tcp      = head.is_tcp;
  assign tcp_flags   = head.tcp_flags;
  assign seq_num     = head.seq_num;
  assign ack_num     = head.ack_num;
  assign next_seq    = head.next_seq;
  assign payload_len = head.payload_len;
  assign ts_present  = head.ts_present;
  assign ts_val      = head.ts_val;
  assign ts_ecr      = head.ts_ecr;
  assign src_port    = head.src_port;
endmodule

// File: tb/tb_tcp_hdr_extract.sv
// Directed bench for tcp_hdr_extract: a 256-bit instance for most packets and a 64-bit
// instance for the narrow-bus FIN packet.
module tb_tcp_hdr_extract;
  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [255:0] tdata_a = '0;
  logic         tvalid_a = 1'b0, tready_a = 1'b1, tlast_a = 1'b0, rd_en_a = 1'b0;
  logic [127:0] tuser_a = '0;
  logic         meta_vld_a, is_tcp_a, ts_present_a;
  logic [7:0]   tcp_flags_a, src_port_a;
  logic [31:0]  seq_num_a, ack_num_a, next_seq_a, ts_val_a, ts_ecr_a;
  logic [15:0]  payload_len_a, pkt_count_a, drop_count_a;

  logic [63:0]  tdata_b = '0;
  logic         tvalid_b = 1'b0, tready_b = 1'b1, tlast_b = 1'b0, rd_en_b = 1'b0;
  logic [127:0] tuser_b = '0;
  logic         meta_vld_b, is_tcp_b, ts_present_b;
  logic [7:0]   tcp_flags_b, src_port_b;
  logic [31:0]  seq_num_b, ack_num_b, next_seq_b, ts_val_b, ts_ecr_b;
  logic [15:0]  payload_len_b, pkt_count_b, drop_count_b;

  tcp_hdr_extract #(.C_S_AXIS_DATA_WIDTH(256), .C_S_AXIS_TUSER_WIDTH(128), .FIFO_DEPTH_BITS(5)) dut_a (
    .clk(clk), .reset(reset), .tdata(tdata_a), .tvalid(tvalid_a), .tready(tready_a),
    .tlast(tlast_a), .tuser(tuser_a), .rd_en(rd_en_a), .meta_vld(meta_vld_a),
    .is_tcp(is_tcp_a), .tcp_flags(tcp_flags_a), .seq_num(seq_num_a), .ack_num(ack_num_a),
    .next_seq(next_seq_a), .payload_len(payload_len_a), .ts_present(ts_present_a),
    .ts_val(ts_val_a), .ts_ecr(ts_ecr_a), .src_port(src_port_a),
    .pkt_count(pkt_count_a), .drop_count(drop_count_a));

  tcp_hdr_extract #(.C_S_AXIS_DATA_WIDTH(64), .C_S_AXIS_TUSER_WIDTH(128), .FIFO_DEPTH_BITS(5)) dut_b (
    .clk(clk), .reset(reset), .tdata(tdata_b), .tvalid(tvalid_b), .tready(tready_b),
    .tlast(tlast_b), .tuser(tuser_b), .rd_en(rd_en_b), .meta_vld(meta_vld_b),
    .is_tcp(is_tcp_b), .tcp_flags(tcp_flags_b), .seq_num(seq_num_b), .ack_num(ack_num_b),
    .next_seq(next_seq_b), .payload_len(payload_len_b), .ts_present(ts_present_b),
    .ts_val(ts_val_b), .ts_ecr(ts_ecr_b), .src_port(src_port_b),
    .pkt_count(pkt_count_b), .drop_count(drop_count_b));

  int checks = 0;
  int failures = 0;
  logic [7:0] pkt [0:255];

  // scoreboard primitive
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rec(input string tag, input bit sel_b, input logic e_tcp,
                           input logic [7:0] e_flags, input logic [31:0] e_seq,
                           input logic [31:0] e_ack, input logic [31:0] e_next,
                           input logic [15:0] e_len, input logic e_tsp,
                           input logic [31:0] e_tsv, input logic [31:0] e_tse,
                           input logic [7:0] e_sp);
    logic [193:0] o;
    o = sel_b ? {is_tcp_b, tcp_flags_b, seq_num_b, ack_num_b, next_seq_b, payload_len_b,
                 ts_present_b, ts_val_b, ts_ecr_b, src_port_b}
              : {is_tcp_a, tcp_flags_a, seq_num_a, ack_num_a, next_seq_a, payload_len_a,
                 ts_present_a, ts_val_a, ts_ecr_a, src_port_a};
    chk({tag, ".is_tcp"},      64'(o[193]),     64'(e_tcp));
    chk({tag, ".tcp_flags"},   64'(o[192:185]), 64'(e_flags));
    chk({tag, ".seq_num"},     64'(o[184:153]), 64'(e_seq));
    chk({tag, ".ack_num"},     64'(o[152:121]), 64'(e_ack));
    chk({tag, ".next_seq"},    64'(o[120:89]),  64'(e_next));
    chk({tag, ".payload_len"}, 64'(o[88:73]),   64'(e_len));
    chk({tag, ".ts_present"},  64'(o[72]),      64'(e_tsp));
    chk({tag, ".ts_val"},      64'(o[71:40]),   64'(e_tsv));
    chk({tag, ".ts_ecr"},      64'(o[39:8]),    64'(e_tse));
    chk({tag, ".src_port"},    64'(o[7:0]),     64'(e_sp));
  endtask

  // packet builder: random filler, then the header fields the decoder looks at
  task automatic build_tcp(input logic [7:0] proto, input logic [15:0] ip_len,
                           input logic [31:0] seq, input logic [31:0] ack,
                           input logic [7:0] flags, input logic [3:0] doff,
                           input int ts_mode, input logic [31:0] tsv, input logic [31:0] tse);
    for (int i = 0; i < 256; i++) pkt[i] = 8'($urandom_range(0, 255));
    pkt[12] = 8'h08; pkt[13] = 8'h00; pkt[14] = 8'h45;
    pkt[16] = ip_len[15:8]; pkt[17] = ip_len[7:0];
    pkt[23] = proto;
    for (int i = 0; i < 4; i++) begin
      pkt[38+i] = seq[31-8*i -: 8];
      pkt[42+i] = ack[31-8*i -: 8];
    end
    pkt[46] = {doff, 4'h0};
    pkt[47] = flags;
    if (ts_mode == 1) begin
      pkt[54] = 8'h08; pkt[55] = 8'h0a;
      for (int i = 0; i < 4; i++) begin
        pkt[56+i] = tsv[31-8*i -: 8];
        pkt[60+i] = tse[31-8*i -: 8];
      end
    end else if (ts_mode == 2) begin
      pkt[54] = 8'h01; pkt[55] = 8'h01; pkt[56] = 8'h08; pkt[57] = 8'h0a;
      for (int i = 0; i < 4; i++) begin
        pkt[58+i] = tsv[31-8*i -: 8];
        pkt[62+i] = tse[31-8*i -: 8];
      end
    end
  endtask

  // driver tasks
  task automatic drive_beat_a(input int b, input int len, input logic [7:0] sp);
    @(negedge clk);
    for (int k = 0; k < 32; k++) tdata_a[8*k +: 8] = (b*32 + k < len) ? pkt[b*32 + k] : 8'h00;
    tvalid_a = 1'b1;
    tlast_a  = (b == (len + 31) / 32 - 1);
    tuser_a  = '0;
    tuser_a[23:16] = sp;
  endtask

  task automatic send_a(input int len, input logic [7:0] sp);
    for (int b = 0; b < (len + 31) / 32; b++) drive_beat_a(b, len, sp);
  endtask

  task automatic idle_a();
    @(negedge clk);
    tvalid_a = 1'b0;
    tlast_a  = 1'b0;
  endtask

  task automatic send_b(input int len, input logic [7:0] sp);
    for (int b = 0; b < (len + 7) / 8; b++) begin
      @(negedge clk);
      for (int k = 0; k < 8; k++) tdata_b[8*k +: 8] = (b*8 + k < len) ? pkt[b*8 + k] : 8'h00;
      tvalid_b = 1'b1;
      tlast_b  = (b == (len + 7) / 8 - 1);
      tuser_b  = '0;
      tuser_b[23:16] = sp;
      @(negedge clk);
      tvalid_b = 1'b0;
      tlast_b  = 1'b0;
      tdata_b  = {$urandom, $urandom};
      tuser_b  = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  task automatic pop_a();
    @(negedge clk);
    rd_en_a = 1'b1;
    @(negedge clk);
    rd_en_a = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst.meta_vld", 64'(meta_vld_a), 64'd0);
    chk("rst.pkt_count", 64'(pkt_count_a), 64'd0);
    chk("rst.drop_count", 64'(drop_count_a), 64'd0);
    check_rec("rst", 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 32'h0, 16'h0, 1'b0, 32'h0, 32'h0, 8'h00);
    reset = 1'b0;

    // SYN-ACK, 66 bytes in 3 beats, NOP,NOP timestamp layout
    build_tcp(8'd6, 16'd52, 32'h1000_0000, 32'hABCD_0001, 8'h12, 4'd8, 2, 32'h1122_3344, 32'h5566_7788);
    send_a(66, 8'h03);
    idle_a();
    chk("synack.meta_vld_at_N", 64'(meta_vld_a), 64'd0);
    @(negedge clk);
    chk("synack.meta_vld_at_N1", 64'(meta_vld_a), 64'd1);
    check_rec("synack", 1'b0, 1'b1, 8'h12, 32'h1000_0000, 32'hABCD_0001, 32'h1000_0001,
              16'd0, 1'b1, 32'h1122_3344, 32'h5566_7788, 8'h03);
    pop_a();
    chk("synack.popped", 64'(meta_vld_a), 64'd0);

    // PSH|ACK with payload 100, sequence wraps; kind-8-first timestamp layout
    build_tcp(8'd6, 16'd152, 32'hFFFF_FFF0, 32'h0000_0042, 8'h18, 4'd8, 1, 32'hAABB_CCDD, 32'h0102_0304);
    send_a(166, 8'h05);
    idle_a();
    @(negedge clk);
    check_rec("pshack", 1'b0, 1'b1, 8'h18, 32'hFFFF_FFF0, 32'h0000_0042, 32'h0000_0054,
              16'd100, 1'b1, 32'hAABB_CCDD, 32'h0102_0304, 8'h05);
    chk("pshack.pkt_count", 64'(pkt_count_a), 64'd2);
    pop_a();

    // UDP then a 40-byte runt, back to back
    pulse_reset();
    chk("udp.pkt_after_reset", 64'(pkt_count_a), 64'd0);
    build_tcp(8'd17, 16'd52, 32'h2222_2222, 32'h3333_3333, 8'h12, 4'd8, 2, 32'h1, 32'h2);
    send_a(66, 8'h07);
    build_tcp(8'd6, 16'd52, 32'h1111_1111, 32'h4444_4444, 8'h12, 4'd8, 2, 32'h1, 32'h2);
    send_a(40, 8'h09);
    idle_a();
    @(negedge clk);
    chk("udp.pkt_count", 64'(pkt_count_a), 64'd2);
    chk("udp.meta_vld", 64'(meta_vld_a), 64'd1);
    chk("udp.is_tcp", 64'(is_tcp_a), 64'd0);
    chk("udp.src_port", 64'(src_port_a), 64'h07);
    pop_a();
    chk("runt.meta_vld", 64'(meta_vld_a), 64'd1);
    check_rec("runt", 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 32'h0, 16'h0, 1'b0, 32'h0, 32'h0, 8'h09);
    pop_a();
    chk("runt.popped", 64'(meta_vld_a), 64'd0);

    // FIN|ACK, no options: 256-bit bus, then 64-bit bus with gaps between beats
    build_tcp(8'd6, 16'd40, 32'h1234_5678, 32'h9ABC_DEF0, 8'h11, 4'd5, 0, 32'h0, 32'h0);
    send_a(66, 8'h0A);
    idle_a();
    @(negedge clk);
    check_rec("fin256", 1'b0, 1'b1, 8'h11, 32'h1234_5678, 32'h9ABC_DEF0, 32'h1234_5679,
              16'd0, 1'b0, 32'h0, 32'h0, 8'h0A);
    pop_a();
    send_b(66, 8'h0A);
    chk("fin64.meta_vld_at_N", 64'(meta_vld_b), 64'd0);
    @(negedge clk);
    chk("fin64.meta_vld_at_N1", 64'(meta_vld_b), 64'd1);
    chk("fin64.pkt_count", 64'(pkt_count_b), 64'd1);
    check_rec("fin64", 1'b1, 1'b1, 8'h11, 32'h1234_5678, 32'h9ABC_DEF0, 32'h1234_5679,
              16'd0, 1'b0, 32'h0, 32'h0, 8'h0A);

    // 40 back-to-back packets into a 32-deep FIFO, then drain in order
    pulse_reset();
    for (int i = 0; i < 40; i++) begin
      build_tcp(8'd6, 16'd40, 32'(i), 32'h0, 8'h10, 4'd5, 0, 32'h0, 32'h0);
      send_a(66, 8'(i));
    end
    idle_a();
    repeat (2) @(negedge clk);
    chk("fill.pkt_count", 64'(pkt_count_a), 64'd40);
    chk("fill.drop_count", 64'(drop_count_a), 64'd8);
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("drain%0d.meta_vld", i), 64'(meta_vld_a), 64'd1);
      chk($sformatf("drain%0d.seq_num", i), 64'(seq_num_a), 64'(i));
      pop_a();
    end
    chk("drain.empty", 64'(meta_vld_a), 64'd0);

    // reset lands on the second beat of a packet, then one clean packet
    pulse_reset();
    build_tcp(8'd6, 16'd40, 32'hCAFE_0001, 32'h0, 8'h10, 4'd5, 0, 32'h0, 32'h0);
    drive_beat_a(0, 66, 8'h0B);
    drive_beat_a(1, 66, 8'h0B);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tvalid_a = 1'b0;
    tlast_a  = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst.meta_vld", 64'(meta_vld_a), 64'd0);
    chk("midrst.pkt_count", 64'(pkt_count_a), 64'd0);
    build_tcp(8'd6, 16'd40, 32'hBEEF_0000, 32'h0000_0077, 8'h02, 4'd5, 0, 32'h0, 32'h0);
    send_a(66, 8'h0C);
    idle_a();
    @(negedge clk);
    chk("clean.pkt_count", 64'(pkt_count_a), 64'd1);
    check_rec("clean", 1'b0, 1'b1, 8'h02, 32'hBEEF_0000, 32'h0000_0077, 32'hBEEF_0001,
              16'd0, 1'b0, 32'h0, 32'h0, 8'h0C);
    pop_a();
    chk("clean.single_record", 64'(meta_vld_a), 64'd0);
    chk("clean.drop_count", 64'(drop_count_a), 64'd0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
